// File: rtl/alu_exec.sv
// Registered execute stage behind the ALU control decoder: one-cycle logic/arith/compare,
// iterative one-bit-per-cycle shifts, valid/ready handshake on both sides.
module alu_exec #(
    parameter int W  = 32,
    parameter int SW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic [2:0]    aluctrl,
    input  logic          SA_sel,
    input  logic          AL_sel,
    input  logic          LR_sel,
    input  logic          US_sel,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  result,
    output logic          zero,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SLL = 3'b001;
    localparam logic [2:0] OP_SLT = 3'b010;
    localparam logic [2:0] OP_PSB = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SRX = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_AND = 3'b111;

    state_t         state_q, state_d;
    logic [W-1:0]   shreg_q, shreg_d;
    logic [SW-1:0]  cnt_q, cnt_d;
    logic           left_q, left_d;
    logic           fill_q, fill_d;
    logic [W-1:0]   result_q, result_d;
    logic           zero_q, zero_d;

    // Direction comes from aluctrl alone; LR_sel is redundant with it.
    logic           unused_lr_sel;
    assign unused_lr_sel = LR_sel;

    logic [SW-1:0]  shamt;
    logic           is_shift;
    logic           start_shift;
    logic           last_step;
    logic [W-1:0]   op_result;
    logic [W-1:0]   shl_step;
    logic [W-1:0]   shr_step;
    logic [W-1:0]   shift_step;

    assign shamt       = b[SW-1:0];
    assign is_shift    = (aluctrl == OP_SLL) || (aluctrl == OP_SRX);
    assign start_shift = is_shift && (shamt != '0);
    assign last_step   = (cnt_q == SW'(1));

    // One-position shift of the working register in either direction.
    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_step
            if (gi == 0) begin : g_lsb
                assign shl_step[gi] = 1'b0;
            end else begin : g_lmid
                assign shl_step[gi] = shreg_q[gi-1];
            end
            if (gi == W-1) begin : g_msb
                assign shr_step[gi] = fill_q;
            end else begin : g_rmid
                assign shr_step[gi] = shreg_q[gi+1];
            end
        end
    endgenerate

    assign shift_step = left_q ? shl_step : shr_step;

    // Single-cycle result; a shift reaching here has amount 0 and passes a.
    always_comb begin
        op_result = '0;
        case (aluctrl)
            OP_ADD: op_result = SA_sel ? (a - b) : (a + b);
            OP_SLT: op_result = {{(W-1){1'b0}},
                                 (US_sel ? (a < b) : ($signed(a) < $signed(b)))};
            OP_PSB: op_result = b;
            OP_XOR: op_result = a ^ b;
            OP_OR:  op_result = a | b;
            OP_AND: op_result = a & b;
            OP_SLL: op_result = a;
            OP_SRX: op_result = a;
            default: op_result = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = start_shift ? S_SHIFT : S_DONE;
                end
            end
            S_SHIFT: begin
                if (last_step) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state only
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        busy      = (state_q == S_SHIFT) || (state_q == S_DONE);
    end

    // Datapath next values
    always_comb begin
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        left_d   = left_q;
        fill_d   = fill_q;
        result_d = result_q;
        zero_d   = zero_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (start_shift) begin
                        shreg_d = a;
                        cnt_d   = shamt;
                        left_d  = (aluctrl == OP_SLL);
                        fill_d  = (aluctrl == OP_SRX) && AL_sel && a[W-1];
                    end else begin
                        result_d = op_result;
                        zero_d   = (op_result == '0);
                    end
                end
            end
            S_SHIFT: begin
                shreg_d = shift_step;
                cnt_d   = cnt_q - SW'(1);
                if (last_step) begin
                    result_d = shift_step;
                    zero_d   = (shift_step == '0);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q  <= '0;
            cnt_q    <= '0;
            left_q   <= 1'b0;
            fill_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            left_q   <= left_d;
            fill_q   <= fill_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign result = result_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_alu_exec.sv
// Directed self-checking bench for alu_exec: ops, shift latency, backpressure, reset mid-shift.
module tb_alu_exec;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  aluctrl;
    logic        SA_sel;
    logic        AL_sel;
    logic        LR_sel;
    logic        US_sel;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        busy;

    int checks;
    int errors;

    alu_exec #(.W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .aluctrl   (aluctrl),
        .SA_sel    (SA_sel),
        .AL_sel    (AL_sel),
        .LR_sel    (LR_sel),
        .US_sel    (US_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [31:0] av, input logic [31:0] bv, input logic [2:0] ctrl,
                          input logic sa, input logic al, input logic us);
        a       = av;
        b       = bv;
        aluctrl = ctrl;
        SA_sel  = sa;
        AL_sel  = al;
        US_sel  = us;
        LR_sel  = (ctrl == 3'b001);
    endtask

    // One complete transaction with immediate consumption; latency counted from the acceptance edge.
    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic [2:0] ctrl, input logic sa, input logic al, input logic us,
                          input logic [31:0] exp_res, input int exp_lat);
        int lat;
        @(negedge clk);
        chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        set_in(av, bv, ctrl, sa, al, us);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        $display("op %s ctrl=%b a=%h b=%h result=%h zero=%b latency=%0d",
                 tag, ctrl, av, bv, result, zero, lat);
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_result"}, result, exp_res);
        chk({tag, "_zero"}, {31'b0, zero}, {31'b0, (exp_res == 32'd0)});
        @(posedge clk);
        #1;
        chk({tag, "_consumed"}, {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        set_in(32'd0, 32'd0, 3'b000, 1'b0, 1'b0, 1'b0);
        #3;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_busy",      {31'b0, busy},      32'd0);
        chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
        chk("rst_result",    result,             32'd0);
        chk("rst_zero",      {31'b0, zero},      32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_op("add",      32'h0000_0005, 32'h0000_0003, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0000_0008, 1);
        run_op("sub_zero", 32'h0000_0007, 32'h0000_0007, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1);
        run_op("sub_wrap", 32'h0000_0003, 32'h0000_0005, 3'b000, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 1);
        run_op("slt_s",    32'hFFFF_FFFF, 32'h0000_0001, 3'b010, 1'b0, 1'b0, 1'b0, 32'h0000_0001, 1);
        run_op("slt_u",    32'hFFFF_FFFF, 32'h0000_0001, 3'b010, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1);
        run_op("pass_b",   32'h1111_1111, 32'hDEAD_BEEF, 3'b011, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 1);
        run_op("xor",      32'hF0F0_F0F0, 32'hFFFF_0000, 3'b100, 1'b0, 1'b0, 1'b0, 32'h0F0F_F0F0, 1);
        run_op("or",       32'hF0F0_0000, 32'h0000_0F0F, 3'b110, 1'b0, 1'b0, 1'b0, 32'hF0F0_0F0F, 1);
        run_op("and",      32'hFF00_FF00, 32'h0F0F_0F0F, 3'b111, 1'b0, 1'b0, 1'b0, 32'h0F00_0F00, 1);
        run_op("sra4",     32'h8000_0010, 32'h0000_0004, 3'b101, 1'b0, 1'b1, 1'b0, 32'hF800_0001, 5);
        run_op("srl4",     32'h8000_0010, 32'h0000_0004, 3'b101, 1'b0, 1'b0, 1'b0, 32'h0800_0001, 5);
        run_op("sll31",    32'h0000_0001, 32'h0000_001F, 3'b001, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32);
        run_op("sll_out",  32'h8000_0001, 32'h0000_0001, 3'b001, 1'b0, 1'b0, 1'b0, 32'h0000_0002, 2);
        run_op("shr_mask", 32'h1234_5678, 32'h0000_0020, 3'b101, 1'b0, 1'b1, 1'b0, 32'h1234_5678, 1);
        run_op("shl_zero", 32'h8765_4321, 32'h0000_0000, 3'b001, 1'b0, 1'b0, 1'b0, 32'h8765_4321, 1);

        // Backpressure: result held in DONE, pending request ignored until consumed.
        @(negedge clk);
        set_in(32'd10, 32'd20, 3'b000, 1'b0, 1'b0, 1'b0);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        set_in(32'hF0F0_F0F0, 32'hFFFF_0000, 3'b100, 1'b0, 1'b0, 1'b0);
        chk("bp_valid", {31'b0, out_valid}, 32'd1);
        chk("bp_result", result, 32'd30);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_result", result, 32'd30);
            chk("bp_hold_in_ready", {31'b0, in_ready}, 32'd0);
            chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
        end
        $display("op backpressure held result=%h for 10 cycles", result);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_valid", {31'b0, out_valid}, 32'd0);
        chk("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_next_valid", {31'b0, out_valid}, 32'd1);
        chk("bp_next_result", result, 32'h0F0F_F0F0);
        $display("op backpressure next ctrl=100 result=%h", result);
        @(posedge clk);
        #1;
        chk("bp_next_consumed", {31'b0, out_valid}, 32'd0);

        // Reset asserted in the middle of a 20-cycle shift.
        @(negedge clk);
        set_in(32'h0000_0001, 32'd20, 3'b001, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        chk("mid_busy_before", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid",    {31'b0, out_valid}, 32'd0);
        chk("mid_rst_busy",     {31'b0, busy},      32'd0);
        chk("mid_rst_result",   result,             32'd0);
        chk("mid_rst_zero",     {31'b0, zero},      32'd1);
        chk("mid_rst_in_ready", {31'b0, in_ready},  32'd1);
        $display("op reset mid-shift result=%h busy=%b", result, busy);
        @(negedge clk);
        rst = 1'b0;
        run_op("post_rst", 32'h0000_0001, 32'h0000_0003, 3'b001, 1'b0, 1'b0, 1'b0, 32'h0000_0008, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
